atm_multi_account_ctrl: RTL
===========================

ATM_MULTI_ACCOUNT_CTRL -- requirements
Module: atm_multi_account_ctrl

Interface
REQ-001 Parameter N_ACCOUNTS, default 4, number of accounts (>=2).
REQ-002 Parameter PIN_W, default 4, PIN width.
REQ-003 Parameter AMT_W, default 7, transaction amount width.
REQ-004 Parameter BAL_W, default 32, balance width; BAL_W > AMT_W.
REQ-005 Parameter MAX_TRIES, default 3, wrong-PIN attempts before lockout.
REQ-006 Parameter PIN_TABLE, default 16'hDCBA, packed N_ACCOUNTS*PIN_W vector; account i PIN = slice i.
REQ-007 Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- card_in  in  1  card present level.
- account_id  in  AW=$clog2(N_ACCOUNTS)  account selected on card entry.
- pin_valid / pin  in  1 / PIN_W  PIN entry strobe / value.
- op_valid / op_code  in  1 / 2  request strobe; 00 balance, 01 deposit, 10 withdraw, 11 end.
- amount  in  AMT_W  unsigned amount.
- eject_card  in  1  user abort.
- pin_ok  out  1  level, session authenticated.
- op_done / op_error  out  1 / 1  one-cycle pulses on completion / rejection.
- error_code  out  2  00 none, 01 insufficient funds, 10 overflow, 11 locked; held until next op.
- balance_out  out  BAL_W  selected account balance after last op.
- card_ejected  out  1  level while in EJECT.
- busy  out  1  high in any state except IDLE.

Function
REQ-008 States: IDLE, PIN_WAIT, MENU, EXEC, EJECT; one-hot or binary, implementer's choice.
REQ-009 IDLE: card_in=1 at edge k latches account_id; PIN_WAIT from k.
REQ-010 PIN_WAIT: pin_valid with pin==PIN_TABLE slice -> MENU, pin_ok=1, try counter cleared; mismatch -> try counter +1, stay.
REQ-011 MENU: op_valid sampled at edge k -> EXEC; op_code/amount latched at k; inputs ignored while in EXEC.
REQ-012 EXEC: at edge k+1 balance updated, op_done or op_error pulses exactly one cycle, state -> MENU (or EJECT for op 11).
REQ-013 Deposit: balance+amount computed BAL_W+1 wide; carry out -> op_error, code 10, balance unchanged.
REQ-014 Withdraw: amount > balance -> op_error, code 01, balance unchanged; amount==balance legal, result 0.
REQ-015 amount==0 deposit/withdraw -> op_done, balance unchanged.
REQ-016 Balance op -> op_done, balance_out refreshed, no modification.
REQ-017 eject_card=1 or card_in=0 in PIN_WAIT/MENU/EXEC -> EJECT next edge; eject wins over simultaneous pin_valid/op_valid; an EXEC already entered completes its update first.
REQ-018 EJECT: card_ejected=1, pin_ok=0, try counter cleared; -> IDLE when card_in=0.
REQ-019 Balances persist across sessions; only reset clears them.

Reset
REQ-020 Reset asserted: state IDLE, all balances 0, try counter 0, lock bits 0, all outputs 0, mid-transaction update discarded.
REQ-021 Reset deassertion honoured on the first clk edge after release.

Configuration
REQ-022 ATM_PIN_LOCKOUT_EN defined: MAX_TRIES-th consecutive mismatch sets account lock bit, pulses op_error code 11, -> EJECT; card entry on locked account -> EJECT next edge with op_error code 11; lock sticky until reset.
REQ-023 ATM_PIN_LOCKOUT_EN undefined: unlimited retries, no lock bits, code 11 never produced.

Structure
REQ-024 Package atm_pkg holds state enum, op_code constants, error_code constants.
REQ-025 Sub-module atm_account_bank: N_ACCOUNTS x BAL_W register file, one read port, one write port, async reset.

Verification
REQ-026 Card acct0, pin 4'hA, deposit 100 -> pin_ok=1, op_done one cycle, balance_out=100.
REQ-027 Acct0 balance 100, withdraw 101 -> op_error, code 01, balance 100; withdraw 100 -> balance 0.
REQ-028 BAL_W=8, balance 200, deposit 100 -> op_error code 10, balance 200.
REQ-029 Lockout on: acct1 three wrong PINs -> code 11, EJECT; reinsert acct1 -> immediate EJECT; acct2 unaffected.
REQ-030 eject_card with op_valid same edge in MENU -> EJECT, no op_done, balance unchanged.
REQ-031 Reset during EXEC deposit 50 -> IDLE, all balances 0, outputs 0.

Source files
------------

// File: rtl/atm_multi_account_ctrl_pkg.sv
// Shared types for the multi-account ATM controller: FSM state encoding,
// operation codes and error codes seen on error_code.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PIN_WAIT,
        ST_MENU,
        ST_EXEC,
        ST_EJECT
    } state_t;

    localparam logic [1:0] OP_BALANCE  = 2'b00;
    localparam logic [1:0] OP_DEPOSIT  = 2'b01;
    localparam logic [1:0] OP_WITHDRAW = 2'b10;
    localparam logic [1:0] OP_END      = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_FUNDS    = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_LOCKED   = 2'b11;

endpackage

// File: rtl/atm_multi_account_ctrl_if.sv
// User-side bus of the ATM controller.
//   master : card/PIN/op requests in, status and results back
//   slave  : the controller side
interface atm_multi_account_ctrl_if #(
    parameter int N_ACCOUNTS = 4,
    parameter int PIN_W      = 4,
    parameter int AMT_W      = 7,
    parameter int BAL_W      = 32
);
    localparam int AW = $clog2(N_ACCOUNTS);

    logic             card_in;
    logic [AW-1:0]    account_id;
    logic             pin_valid;
    logic [PIN_W-1:0] pin;
    logic             op_valid;
    logic [1:0]       op_code;
    logic [AMT_W-1:0] amount;
    logic             eject_card;
    logic             pin_ok;
    logic             op_done;
    logic             op_error;
    logic [1:0]       error_code;
    logic [BAL_W-1:0] balance_out;
    logic             card_ejected;
    logic             busy;

    modport master (
        output card_in, account_id, pin_valid, pin, op_valid, op_code, amount, eject_card,
        input  pin_ok, op_done, op_error, error_code, balance_out, card_ejected, busy
    );

    modport slave (
        input  card_in, account_id, pin_valid, pin, op_valid, op_code, amount, eject_card,
        output pin_ok, op_done, op_error, error_code, balance_out, card_ejected, busy
    );

endinterface

// File: rtl/atm_multi_account_ctrl_bank.sv
// atm_account_bank: N_ACCOUNTS x BAL_W balance register file.
//   clk, reset    : clock, async active-high reset (all balances -> 0)
//   raddr / rdata : combinational read port
//   we/waddr/wdata: synchronous write port
module atm_account_bank #(
    parameter int N_ACCOUNTS = 4,
    parameter int BAL_W      = 32,
    localparam int AW        = $clog2(N_ACCOUNTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    raddr,
    output logic [BAL_W-1:0] rdata,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [BAL_W-1:0] wdata
);

    logic [BAL_W-1:0] bal_q [N_ACCOUNTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_ACCOUNTS; i++) bal_q[i] <= '0;
        end else if (we) begin
            bal_q[waddr] <= wdata;
        end
    end

    assign rdata = bal_q[raddr];

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// atm_multi_account_ctrl: card/PIN/transaction controller over a bank of
// per-account balances.
//   clk, reset : clock, async active-high reset
//   bus        : atm_multi_account_ctrl_if.slave (card, PIN, ops, status)
// Optional build macro ATM_PIN_LOCKOUT_EN: after MAX_TRIES consecutive wrong
// PINs the account is locked (sticky until reset) and the card ejected with
// error code 11. Without it, PIN retries are unlimited.
module atm_multi_account_ctrl
    import atm_pkg::*;
#(
    parameter int N_ACCOUNTS = 4,
    parameter int PIN_W      = 4,
    parameter int AMT_W      = 7,
    parameter int BAL_W      = 32,
    parameter int MAX_TRIES  = 3,
    parameter logic [N_ACCOUNTS*PIN_W-1:0] PIN_TABLE = 16'hDCBA
) (
    input logic clk,
    input logic reset,
    atm_multi_account_ctrl_if.slave bus
);

    localparam int AW = $clog2(N_ACCOUNTS);
    localparam int TW = $clog2(MAX_TRIES + 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    acct_q, acct_d;
    logic [TW-1:0]    tries_q, tries_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] amt_q, amt_d;
    logic             done_q, done_d, err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [BAL_W-1:0] bout_q, bout_d;
`ifdef ATM_PIN_LOCKOUT_EN
    logic [N_ACCOUNTS-1:0] lock_q, lock_d;
`endif

    logic             we;
    logic [BAL_W-1:0] wdata, cur_bal, diff;
    logic [BAL_W:0]   sum;
    logic             short_funds, pin_match, abort;

    atm_account_bank #(.N_ACCOUNTS(N_ACCOUNTS), .BAL_W(BAL_W)) u_bank (
        .clk   (clk),
        .reset (reset),
        .raddr (acct_q),
        .rdata (cur_bal),
        .we    (we),
        .waddr (acct_q),
        .wdata (wdata)
    );

    // One extra bit on the sum so a deposit carry is detected, not wrapped.
    assign sum         = {1'b0, cur_bal} + {{(BAL_W + 1 - AMT_W){1'b0}}, amt_q};
    assign diff        = cur_bal - {{(BAL_W - AMT_W){1'b0}}, amt_q};
    assign short_funds = {{(BAL_W - AMT_W){1'b0}}, amt_q} > cur_bal;
    assign pin_match   = bus.pin == PIN_TABLE[acct_q*PIN_W +: PIN_W];
    assign abort       = bus.eject_card || !bus.card_in;

    always_comb begin
        state_d = state_q;
        acct_d  = acct_q;
        tries_d = tries_q;
        op_d    = op_q;
        amt_d   = amt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        bout_d  = bout_q;
        we      = 1'b0;
        wdata   = cur_bal;
`ifdef ATM_PIN_LOCKOUT_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.card_in) begin
                    acct_d  = bus.account_id;
                    state_d = ST_PIN_WAIT;
                end
            end
            ST_PIN_WAIT: begin
                if (abort) begin
                    state_d = ST_EJECT;
`ifdef ATM_PIN_LOCKOUT_EN
                end else if (lock_q[acct_q]) begin
                    state_d = ST_EJECT;
                    err_d   = 1'b1;
                    code_d  = ERR_LOCKED;
`endif
                end else if (bus.pin_valid) begin
                    if (pin_match) begin
                        state_d = ST_MENU;
                        tries_d = '0;
`ifdef ATM_PIN_LOCKOUT_EN
                    end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                        lock_d[acct_q] = 1'b1;
                        err_d          = 1'b1;
                        code_d         = ERR_LOCKED;
                        state_d        = ST_EJECT;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
`else
                    end else if (tries_q != '1) begin
                        // saturate: the count has no consequence without lockout
                        tries_d = tries_q + 1'b1;
                    end
`endif
                end
            end
            ST_MENU: begin
                if (abort) begin
                    state_d = ST_EJECT;
                end else if (bus.op_valid) begin
                    op_d    = bus.op_code;
                    amt_d   = bus.amount;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // An entered transaction always completes, even on abort.
                state_d = abort ? ST_EJECT : ST_MENU;
                done_d  = 1'b1;
                code_d  = ERR_NONE;
                bout_d  = cur_bal;
                case (op_q)
                    OP_DEPOSIT: begin
                        if (sum[BAL_W]) begin
                            done_d = 1'b0;
                            err_d  = 1'b1;
                            code_d = ERR_OVERFLOW;
                        end else begin
                            we     = 1'b1;
                            wdata  = sum[BAL_W-1:0];
                            bout_d = sum[BAL_W-1:0];
                        end
                    end
                    OP_WITHDRAW: begin
                        if (short_funds) begin
                            done_d = 1'b0;
                            err_d  = 1'b1;
                            code_d = ERR_FUNDS;
                        end else begin
                            we     = 1'b1;
                            wdata  = diff;
                            bout_d = diff;
                        end
                    end
                    OP_END:  state_d = ST_EJECT;
                    default: ;
                endcase
            end
            ST_EJECT: begin
                tries_d = '0;
                if (!bus.card_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acct_q  <= '0;
            tries_q <= '0;
            op_q    <= '0;
            amt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            bout_q  <= '0;
        end else begin
            state_q <= state_d;
            acct_q  <= acct_d;
            tries_q <= tries_d;
            op_q    <= op_d;
            amt_q   <= amt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            bout_q  <= bout_d;
        end
    end

`ifdef ATM_PIN_LOCKOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= '0;
        else       lock_q <= lock_d;
    end
`endif

    assign bus.pin_ok       = (state_q == ST_MENU) || (state_q == ST_EXEC);
    assign bus.card_ejected = state_q == ST_EJECT;
    assign bus.busy         = state_q != ST_IDLE;
    assign bus.op_done      = done_q;
    assign bus.op_error     = err_q;
    assign bus.error_code   = code_q;
    assign bus.balance_out  = bout_q;

endmodule
